mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/booth_step.sv | 28 ++
 rtl/mult_div.sv | 164 ++++++++++++++++
 tb/tb_mult_div.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants and FSM encoding for the iterative signed multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step on the {hi_acc, lo_acc, q-1} accumulator, followed by an
// arithmetic right shift.
module booth_step
    import mult_div_pkg::*;
(
    input  logic [2*WIDTH:0] acc_in,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_out
);

    logic [WIDTH:0] hi_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // The add/sub is one bit wider so a multiplicand of 0x80000000 cannot overflow;
    // after the shift the true sign lands back inside the 32-bit high half.
    always_comb begin
        hi_ext = {acc_in[2*WIDTH], acc_in[2*WIDTH:WIDTH+1]};
        m_ext  = {mcand[WIDTH-1], mcand};
        case (acc_in[1:0])
            2'b01:   sum = hi_ext + m_ext;
            2'b10:   sum = hi_ext - m_ext;
            default: sum = hi_ext;
        endcase
        acc_out = {sum, acc_in[WIDTH:1]};
    end

endmodule

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiply (Booth) and divide (restoring) unit with HI/LO
// result registers; every operation takes 32 iterate cycles.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_op,
    input  logic             div_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [64:0]      acc_q, acc_d;
    logic [31:0]      mcand_q, mcand_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [64:0]      booth_next;

    booth_step u_booth_step (
        .acc_in  (acc_q),
        .mcand   (mcand_q),
        .acc_out (booth_next)
    );

    // Divide uses the same accumulator: remainder in [64:33], quotient in [32:1].
    logic [31:0] abs_a, abs_b;
    logic [31:0] rem_cur, quo_cur;
    logic [32:0] shifted, diff;
    logic [31:0] rem_next, quo_next;
    logic [64:0] div_next;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        abs_a   = a[31] ? (~a + 32'd1) : a;
        abs_b   = b[31] ? (~b + 32'd1) : b;
        rem_cur = acc_q[64:33];
        quo_cur = acc_q[32:1];
        shifted = {rem_cur, quo_cur[31]};
        diff    = shifted - {1'b0, mcand_q};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo_cur[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            quo_next = {quo_cur[30:0], 1'b0};
        end
        div_next = {rem_next, quo_next, 1'b0};
        quo_fix  = neg_quo_q ? (~quo_next + 32'd1) : quo_next;
        rem_fix  = neg_rem_q ? (~rem_next + 32'd1) : rem_next;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        b_zero_d   = b_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (mult_op) begin
                    state_d = StMult;
                    cnt_d   = CNT_W'(ITERATIONS - 1);
                    acc_d   = {32'd0, a, 1'b0};
                    mcand_d = b;
                end else if (div_op) begin
                    state_d   = StDiv;
                    cnt_d     = CNT_W'(ITERATIONS - 1);
                    acc_d     = {32'd0, abs_a, 1'b0};
                    mcand_d   = abs_b;
                    neg_quo_d = a[31] ^ b[31];
                    neg_rem_d = a[31];
                    b_zero_d  = (b == 32'd0);
                end
            end
            StMult: begin
                acc_d = booth_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    hi_d    = booth_next[64:33];
                    lo_d    = booth_next[32:1];
                end
            end
            StDiv: begin
                if (b_zero_q) begin
                    // Zero divisor: no iterations, results left untouched.
                    state_d    = StDone;
                    cnt_d      = '0;
                    div_zero_d = 1'b1;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            b_zero_q   <= b_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == StMult) || (state_q == StDiv);
    assign done     = (state_q == StDone);
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed, table-driven bench for mult_div: latency, results, flags, priority,
// ignored ops and asynchronous reset.
module tb_mult_div;

    logic        clock;
    logic        reset;
    logic        mult_op;
    logic        div_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    mult_div #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .mult_op  (mult_op),
        .div_op   (div_op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        mop;
        logic        dop;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle. Accept happens at the next posedge.
    task automatic run_op(input vec_t v, input int pulse_at);
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        logic        busy_ok;
        logic        stable_ok;
        logic        dz_ok;
        int          lat;
        bit          seen;
        hi_prev   = hi;
        lo_prev   = lo;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        dz_ok     = 1'b1;
        seen      = 1'b0;
        mult_op   = v.mop;
        div_op    = v.dop;
        a         = v.va;
        b         = v.vb;
        @(posedge clock);
        @(negedge clock);
        mult_op = 1'b0;
        div_op  = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'h0000_0003;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            div_op = (lat == pulse_at - 1) ? 1'b1 : 1'b0;
            @(posedge clock);
            lat++;
            @(negedge clock);
            div_op = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (hi !== hi_prev || lo !== lo_prev) stable_ok = 1'b0;
            if (div_zero) dz_ok = 1'b0;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("latency", lat, v.exp_lat);
            check("busy_held", {31'd0, busy_ok}, 32'd1);
            check("hilo_stable", {31'd0, stable_ok}, 32'd1);
            check("dz_only_with_done", {31'd0, dz_ok}, 32'd1);
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("hi", hi, v.exp_hi);
            check("lo", lo, v.exp_lo);
            check("div_zero", {31'd0, div_zero}, {31'd0, v.exp_dz});
            @(posedge clock);
            @(negedge clock);
            check("done_pulse_end", {31'd0, done}, 32'd0);
            check("dz_pulse_end", {31'd0, div_zero}, 32'd0);
        end
    endtask

    vec_t vecs[14];

    initial begin
        vec_t v;
        vecs[0]  = '{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 32};
        vecs[3]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32};
        vecs[4]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 32};
        vecs[6]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 32};
        vecs[7]  = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 32};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 32};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32};
        vecs[11] = '{1'b1, 1'b1, 32'd9,         32'd5,         32'h0000_0000, 32'd45,        1'b0, 32};
        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 for the zero-divisor case that follows.
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 32};
        vecs[13] = '{1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, 1};

        reset   = 1'b0;
        mult_op = 1'b0;
        div_op  = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clock);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], 0);
        end

        // Both ops together: multiply wins; a div_op pulse mid-operation is ignored.
        v = '{1'b1, 1'b1, 32'd6, 32'd4, 32'd0, 32'd24, 1'b0, 32};
        run_op(v, 10);

        // Asynchronous reset in the middle of a multiply.
        mult_op = 1'b1;
        a       = 32'd7;
        b       = 32'hFFFF_FFFD;
        @(posedge clock);
        @(negedge clock);
        mult_op = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("rst_held_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        v = '{1'b1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 32};
        run_op(v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
